// File: rtl/seq_stage_ctrl.sv
// rtl/seq_stage_ctrl.sv - multi-cycle fetch/decode/execute/memory/writeback sequencer
// Moore stage strobes, registered status and a retired-instruction counter.
module seq_stage_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic        instr_valid,
    input  logic        imem_error,
    input  logic        imem_ready,
    input  logic        mem_access,
    input  logic        dmem_ready,
    input  logic        dmem_error,
    output logic [2:0]  stage,
    output logic        fetch_en,
    output logic        dec_en,
    output logic        exe_en,
    output logic        mem_en,
    output logic        wb_en,
    output logic        pc_en,
    output logic [2:0]  stat,
    output logic        halted,
    output logic [31:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_PCUPD     = 3'd6,
        S_HALT      = 3'd7
    } state_t;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    state_t      state_q;
    state_t      state_d;
    logic [2:0]  stat_q;
    logic [2:0]  stat_d;
    logic [31:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            stat_q  <= STAT_AOK;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            stat_q  <= stat_d;
            if (state_q == S_PCUPD) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        stat_d  = stat_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // Address fault outranks illegal instruction, which outranks halt.
                if (imem_ready) begin
                    if (imem_error) begin
                        stat_d  = STAT_ADR;
                        state_d = S_HALT;
                    end else if (!instr_valid) begin
                        stat_d  = STAT_INS;
                        state_d = S_HALT;
                    end else if (icode == 4'h0) begin
                        stat_d  = STAT_HLT;
                        state_d = S_HALT;
                    end else begin
                        state_d = S_DECODE;
                    end
                end
            end
            S_DECODE:    state_d = S_EXECUTE;
            S_EXECUTE:   state_d = S_MEMORY;
            S_MEMORY: begin
                if (!mem_access) begin
                    state_d = S_WRITEBACK;
                end else if (dmem_ready) begin
                    if (dmem_error) begin
                        stat_d  = STAT_ADR;
                        state_d = S_HALT;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end
            end
            S_WRITEBACK: state_d = S_PCUPD;
            S_PCUPD:     state_d = S_FETCH;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fetch_en = 1'b0;
        dec_en   = 1'b0;
        exe_en   = 1'b0;
        mem_en   = 1'b0;
        wb_en    = 1'b0;
        pc_en    = 1'b0;
        case (state_q)
            S_FETCH:     fetch_en = 1'b1;
            S_DECODE:    dec_en   = 1'b1;
            S_EXECUTE:   exe_en   = 1'b1;
            S_MEMORY:    mem_en   = 1'b1;
            S_WRITEBACK: wb_en    = 1'b1;
            S_PCUPD:     pc_en    = 1'b1;
            default:     ;
        endcase
    end

    assign stage       = state_q;
    assign stat        = stat_q;
    assign halted      = (state_q == S_HALT);
    assign instr_count = count_q;

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// tb/tb_seq_stage_ctrl.sv - randomized and directed checks of seq_stage_ctrl
// An instruction-level plan predicts the stage seen each cycle plus status and count.
module tb_seq_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  icode = 4'h0;
    logic        instr_valid = 1'b0;
    logic        imem_error = 1'b0;
    logic        imem_ready = 1'b0;
    logic        mem_access = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        dmem_error = 1'b0;
    logic [2:0]  stage;
    logic        fetch_en, dec_en, exe_en, mem_en, wb_en, pc_en;
    logic [2:0]  stat;
    logic        halted;
    logic [31:0] instr_count;

    seq_stage_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .icode(icode),
        .instr_valid(instr_valid), .imem_error(imem_error), .imem_ready(imem_ready),
        .mem_access(mem_access), .dmem_ready(dmem_ready), .dmem_error(dmem_error),
        .stage(stage), .fetch_en(fetch_en), .dec_en(dec_en), .exe_en(exe_en),
        .mem_en(mem_en), .wb_en(wb_en), .pc_en(pc_en), .stat(stat),
        .halted(halted), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int          passed = 0;
    int          total = 0;
    logic [2:0]  exp_stat = 3'd1;
    logic [31:0] exp_count = 32'd0;
    int          pc_seen = 0;
    int          wb_seen = 0;
    int          mem_seen = 0;

    function automatic logic r1();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    // Check the cycle the DUT is in, then drive the inputs for that cycle.
    task automatic step(input logic [2:0] es, input logic st, input logic [3:0] ic,
                        input logic iv, input logic ie, input logic ir,
                        input logic ma, input logic dr, input logic de);
        logic [5:0] exp_strb;
        @(negedge clk);
        exp_strb = (es >= 3'd1 && es <= 3'd6) ? (6'b100000 >> (es - 3'd1)) : 6'b000000;
        chk("stage", 32'(stage), 32'(es));
        chk("strobes", 32'({fetch_en, dec_en, exe_en, mem_en, wb_en, pc_en}), 32'(exp_strb));
        chk("halted", 32'(halted), 32'(es == 3'd7));
        chk("stat", 32'(stat), 32'(exp_stat));
        chk("instr_count", instr_count, exp_count);
        if (pc_en) pc_seen++;
        if (wb_en) wb_seen++;
        if (mem_en) mem_seen++;
        start = st; icode = ic; instr_valid = iv; imem_error = ie; imem_ready = ir;
        mem_access = ma; dmem_ready = dr; dmem_error = de;
        @(posedge clk);
    endtask

    task automatic step_rand(input logic [2:0] es);
        step(es, r1(), 4'($urandom), r1(), r1(), r1(), r1(), r1(), r1());
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst_n = 1'b0;
            start = r1(); icode = 4'($urandom); instr_valid = r1(); imem_error = r1();
            imem_ready = r1(); mem_access = r1(); dmem_ready = r1(); dmem_error = r1();
            @(posedge clk);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        exp_stat = 3'd1;
        exp_count = 32'd0;
    endtask

    // One instruction as seen by the outside world; reports whether it ended in HALT.
    task automatic run_instr(input int fw, input logic ie, input logic iv, input logic [3:0] ic,
                             input logic ma, input int mw, input logic de, output logic hlt);
        for (int i = 0; i < fw; i++)
            step(3'd1, r1(), 4'($urandom), r1(), r1(), 1'b0, r1(), r1(), r1());
        step(3'd1, r1(), ic, iv, ie, 1'b1, r1(), r1(), r1());
        if (ie)             exp_stat = 3'd3;
        else if (!iv)       exp_stat = 3'd4;
        else if (ic == 4'h0) exp_stat = 3'd2;
        hlt = (exp_stat != 3'd1);
        if (hlt) return;
        step_rand(3'd2);
        step_rand(3'd3);
        if (ma) begin
            for (int i = 0; i < mw; i++)
                step(3'd4, r1(), 4'($urandom), r1(), r1(), r1(), 1'b1, 1'b0, r1());
            step(3'd4, r1(), 4'($urandom), r1(), r1(), r1(), 1'b1, 1'b1, de);
            if (de) begin
                exp_stat = 3'd3;
                hlt = 1'b1;
                return;
            end
        end else begin
            step(3'd4, r1(), 4'($urandom), r1(), r1(), r1(), 1'b0, r1(), r1());
        end
        step_rand(3'd5);
        step_rand(3'd6);
        exp_count = exp_count + 32'd1;
    endtask

    task automatic idle_start();
        step(3'd0, 1'b0, 4'($urandom), r1(), r1(), r1(), r1(), r1(), r1());
        step(3'd0, 1'b1, 4'($urandom), r1(), r1(), r1(), r1(), r1(), r1());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic hlt;
        logic [31:0] count_at_halt;

        // Reset state, then IDLE ignores cycles with start low.
        do_reset(2);
        for (int i = 0; i < 3; i++)
            step(3'd0, 1'b0, 4'($urandom), r1(), r1(), r1(), r1(), r1(), r1());
        step(3'd0, 1'b1, 4'h6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Three plain instructions, zero wait.
        pc_seen = 0;
        for (int i = 0; i < 3; i++) begin
            run_instr(0, 1'b0, 1'b1, 4'h6, 1'b0, 0, 1'b0, hlt);
            chk("aok_no_halt", 32'(hlt), 32'd0);
        end
        chk("pc_pulses", 32'(pc_seen), 32'd3);

        // Halt instruction: no writeback, count frozen, start ignored.
        pc_seen = 0; wb_seen = 0;
        count_at_halt = exp_count;
        run_instr(1, 1'b0, 1'b1, 4'h0, 1'b0, 0, 1'b0, hlt);
        for (int i = 0; i < 4; i++)
            step(3'd7, 1'b1, 4'($urandom), r1(), r1(), r1(), r1(), r1(), r1());
        chk("halt_stat", 32'(stat), 32'd2);
        chk("halt_count", instr_count, count_at_halt);
        chk("halt_no_wb_pc", 32'(wb_seen + pc_seen), 32'd0);

        // Address fault outranks illegal instruction and halt code.
        do_reset(1);
        idle_start();
        run_instr(0, 1'b1, 1'b0, 4'h0, 1'b0, 0, 1'b0, hlt);
        step_rand(3'd7);
        chk("adr_priority", 32'(stat), 32'd3);

        // Data memory wait of four cycles ending in an address fault.
        do_reset(1);
        idle_start();
        mem_seen = 0; wb_seen = 0;
        run_instr(0, 1'b0, 1'b1, 4'h5, 1'b1, 4, 1'b1, hlt);
        step_rand(3'd7);
        step_rand(3'd7);
        chk("dmem_mem_en_cycles", 32'(mem_seen), 32'd5);
        chk("dmem_no_wb", 32'(wb_seen), 32'd0);
        chk("dmem_stat", 32'(stat), 32'd3);

        // Reset in the middle of a data memory wait.
        do_reset(1);
        idle_start();
        run_instr(0, 1'b0, 1'b1, 4'h3, 1'b0, 0, 1'b0, hlt);
        step(3'd1, r1(), 4'h4, 1'b1, 1'b0, 1'b1, r1(), r1(), r1());
        step_rand(3'd2);
        step_rand(3'd3);
        step(3'd4, 1'b0, 4'h4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(3'd4, 1'b0, 4'h4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        do_reset(1);
        pc_seen = 0; wb_seen = 0;
        for (int i = 0; i < 3; i++)
            step(3'd0, 1'b0, 4'($urandom), r1(), r1(), r1(), r1(), r1(), r1());
        chk("reset_no_wb_pc", 32'(wb_seen + pc_seen), 32'd0);

        // Counter wrap from all-ones.
        @(posedge clk);
        force dut.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.count_q;
        exp_count = 32'hFFFF_FFFF;
        step(3'd0, 1'b1, 4'h1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        run_instr(0, 1'b0, 1'b1, 4'h2, 1'b0, 0, 1'b0, hlt);
        step(3'd1, 1'b0, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("count_wrap", instr_count, 32'd0);

        // Randomized programs.
        for (int p = 0; p < 25; p++) begin
            do_reset(int'($urandom_range(1, 3)));
            for (int i = 0; i < int'($urandom_range(0, 2)); i++)
                step(3'd0, 1'b0, 4'($urandom), r1(), r1(), r1(), r1(), r1(), r1());
            step(3'd0, 1'b1, 4'($urandom), r1(), r1(), r1(), r1(), r1(), r1());
            hlt = 1'b0;
            for (int n = 0; n < 8 && !hlt; n++) begin
                run_instr(int'($urandom_range(0, 3)),
                          1'($urandom_range(0, 15) == 0),
                          1'($urandom_range(0, 11) != 0),
                          ($urandom_range(0, 9) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                          r1(), int'($urandom_range(0, 3)),
                          1'($urandom_range(0, 9) == 0), hlt);
            end
            if (hlt) begin
                for (int i = 0; i < 3; i++) step_rand(3'd7);
            end else begin
                step(3'd1, r1(), 4'h1, 1'b1, 1'b0, 1'b0, r1(), r1(), r1());
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
